// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - c, STEP bits per clock,
// borrow rippled through a register between slices.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  input  logic             signed_i,
  input  logic             ack_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             ovf_o,
  output logic             zero_o
);
  localparam int NSTEP = WIDTH / STEP;
  localparam int CW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             sgn_q, sgn_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [STEP-1:0]  a_s, b_s, d_s;
  logic             bo_s;

  // operands shift down so the active slice is always at bit 0
  assign a_s = a_q[STEP-1:0];
  assign b_s = b_q[STEP-1:0];
  assign {bo_s, d_s} = {1'b0, a_s} - {1'b0, b_s}
                     - {{STEP{1'b0}}, br_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    sgn_d    = sgn_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          a_d     = a_i;
          b_d     = b_i;
          br_d    = c_i;
          sgn_d   = signed_i;
          cnt_d   = '0;
        end
      end
      RUN: begin
        for (int k = 0; k < NSTEP; k++) begin
          if (cnt_q == CW'(k)) diff_d[k*STEP +: STEP] = d_s;
        end
        a_d   = a_q >> STEP;
        b_d   = b_q >> STEP;
        br_d  = bo_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          borrow_d = bo_s;
          ovf_d    = sgn_q & (a_s[STEP-1] ^ b_s[STEP-1])
                   & (d_s[STEP-1] ^ a_s[STEP-1]);
          zero_d   = (diff_d == '0);
        end
      end
      DONE: begin
        if (ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      sgn_q    <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      sgn_q    <= sgn_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign ready_o  = state_q[0];
  assign busy_o   = state_q[1];
  assign valid_o  = state_q[2];
  assign diff_o   = diff_q;
  assign borrow_o = borrow_q;
  assign ovf_o    = ovf_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: random + directed scoreboard bench for
// serial_subtractor at W16/S4, W4/S1 and W4/S4.
module tb_serial_subtractor;

  typedef struct {
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;

  logic        start = 0, c = 0, sgn = 0, ack = 0;
  logic [15:0] a = 0, b = 0;
  logic        ready, busy, valid, borrow, ovf, zero;
  logic [15:0] diff;

  logic       start4 = 0, c4 = 0, s4 = 0, ack4 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic       rdy_x, bsy_x, vld_x, bo_x, ov_x, z_x;
  logic [3:0] d_x;
  logic       rdy_y, bsy_y, vld_y, bo_y, ov_y, z_y;
  logic [3:0] d_y;

  exp_t        sbq[3][$];
  int          bc[3];
  logic        pv[3];
  logic [18:0] hd[3];

  serial_subtractor #(.WIDTH(16), .STEP(4)) u_main (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_i(a), .b_i(b),
    .c_i(c), .signed_i(sgn), .ack_i(ack), .ready_o(ready),
    .busy_o(busy), .valid_o(valid), .diff_o(diff), .borrow_o(borrow),
    .ovf_o(ovf), .zero_o(zero)
  );

  serial_subtractor #(.WIDTH(4), .STEP(1)) u_x (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .a_i(a4), .b_i(b4),
    .c_i(c4), .signed_i(s4), .ack_i(ack4), .ready_o(rdy_x),
    .busy_o(bsy_x), .valid_o(vld_x), .diff_o(d_x), .borrow_o(bo_x),
    .ovf_o(ov_x), .zero_o(z_x)
  );

  serial_subtractor #(.WIDTH(4), .STEP(4)) u_y (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .a_i(a4), .b_i(b4),
    .c_i(c4), .signed_i(s4), .ack_i(ack4), .ready_o(rdy_y),
    .busy_o(bsy_y), .valid_o(vld_y), .diff_o(d_y), .borrow_o(bo_y),
    .ovf_o(ov_y), .zero_o(z_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // reference: whole-word integer arithmetic
  function automatic exp_t model(int w, longint xa, longint xb,
                                 longint xc, bit xs, int unsigned ec);
    exp_t e;
    longint m, r, sa, sb, rs;
    m = longint'(1) << w;
    r = xa - xb - xc;
    e.diff = 16'((r + m) % m);
    e.borrow = (r < 0);
    sa = (xa >= m / 2) ? xa - m : xa;
    sb = (xb >= m / 2) ? xb - m : xb;
    rs = sa - sb - xc;
    e.ovf = xs && (rs < -(m / 2) || rs >= m / 2);
    e.zero = (e.diff == 16'h0);
    e.cyc = ec;
    return e;
  endfunction

  task automatic mon(input int i, input string nm,
                     input logic rdy, input logic bsy, input logic vld,
                     input logic [15:0] d, input logic bo,
                     input logic ov, input logic z, input int ns);
    exp_t e;
    chk({nm, " onehot"}, 32'(int'(rdy) + int'(bsy) + int'(vld)), 1);
    if (rdy) bc[i] = 0;
    if (bsy) bc[i]++;
    if (vld && pv[i])
      chk({nm, " hold"}, {13'b0, d, bo, ov, z}, {13'b0, hd[i]});
    if (vld && !pv[i]) begin
      if (sbq[i].size() == 0) begin
        chk({nm, " spurious_valid"}, sbq[i].size(), 1);
      end else begin
        e = sbq[i].pop_front();
        chk({nm, " diff"}, 32'(d), 32'(e.diff));
        chk({nm, " borrow"}, 32'(bo), 32'(e.borrow));
        chk({nm, " ovf"}, 32'(ov), 32'(e.ovf));
        chk({nm, " zero"}, 32'(z), 32'(e.zero));
        chk({nm, " latency_cyc"}, cyc, e.cyc);
        chk({nm, " busy_cycles"}, bc[i], ns);
      end
    end
    hd[i] = {d, bo, ov, z};
    pv[i] = vld;
  endtask

  always @(negedge clk) begin
    if (rst_n) mon(0, "w16s4", ready, busy, valid, diff,
                   borrow, ovf, zero, 4);
    else begin pv[0] = 0; bc[0] = 0; end
  end

  always @(negedge clk) begin
    if (rst_n) mon(1, "w4s1", rdy_x, bsy_x, vld_x, {12'b0, d_x},
                   bo_x, ov_x, z_x, 4);
    else begin pv[1] = 0; bc[1] = 0; end
  end

  always @(negedge clk) begin
    if (rst_n) mon(2, "w4s4", rdy_y, bsy_y, vld_y, {12'b0, d_y},
                   bo_y, ov_y, z_y, 1);
    else begin pv[2] = 0; bc[2] = 0; end
  end

  task automatic wait_valid16(input string nm);
    int n = 0;
    while (!valid && n < 40) begin @(negedge clk); n++; end
    chk({nm, " valid_timeout"}, 32'(valid), 1);
  endtask

  task automatic op16(input logic [15:0] xa, input logic [15:0] xb,
                      input logic xc, input logic xs, input int dly);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin @(negedge clk); n++; end
    a = xa; b = xb; c = xc; sgn = xs; start = 1;
    sbq[0].push_back(model(16, xa, xb, xc, xs, cyc + 1 + 4));
    @(negedge clk);
    start = 0;
    a = 16'($urandom); b = 16'($urandom);
    c = 1'($urandom); sgn = 1'($urandom);
    wait_valid16("op16");
    repeat (dly) @(negedge clk);
    ack = 1;
    @(negedge clk);
    ack = 0;
  endtask

  task automatic op4(input logic [3:0] xa, input logic [3:0] xb,
                     input logic xc, input logic xs);
    int n = 0;
    @(negedge clk);
    while (!(rdy_x && rdy_y) && n < 20) begin @(negedge clk); n++; end
    a4 = xa; b4 = xb; c4 = xc; s4 = xs; start4 = 1;
    sbq[1].push_back(model(4, xa, xb, xc, xs, cyc + 1 + 4));
    sbq[2].push_back(model(4, xa, xb, xc, xs, cyc + 1 + 1));
    @(negedge clk);
    start4 = 0;
    a4 = ~xa; b4 = ~xb;
    n = 0;
    while (!(vld_x && vld_y) && n < 20) begin @(negedge clk); n++; end
    chk("op4 valid_timeout", 32'(vld_x & vld_y), 1);
    ack4 = 1;
    @(negedge clk);
    ack4 = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin pv[i] = 0; bc[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst ready", 32'(ready), 1);
    chk("rst busy", 32'(busy), 0);
    chk("rst valid", 32'(valid), 0);
    chk("rst diff", 32'(diff), 0);
    chk("rst flags", {29'b0, borrow, ovf, zero}, 0);
    chk("rst small ready", {30'b0, rdy_x, rdy_y}, 3);
    rst_n = 1;

    op16(16'h1234, 16'h0234, 0, 0, 0);
    op16(16'h0000, 16'h0001, 0, 0, 0);
    op16(16'h0005, 16'h0004, 1, 0, 0);
    op16(16'h8000, 16'h0001, 0, 1, 0);
    op16(16'h7FFF, 16'hFFFF, 0, 1, 0);
    op16(16'h0000, 16'h0000, 1, 1, 0);

    for (int i = 0; i < 200; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom),
           1'($urandom), int'($urandom_range(0, 3)));

    for (int i = 0; i < 512; i++)
      op4(4'(i >> 5), 4'(i >> 1), 1'(i), 1'(i >> 9 == 0 ? i >> 4 : 0));
    for (int i = 0; i < 64; i++)
      op4(4'($urandom), 4'($urandom), 1'($urandom), 1);

    // start held through RUN/DONE, late ack, ack+start together
    @(negedge clk);
    chk("t5 ready", 32'(ready), 1);
    a = 16'h1111; b = 16'h0101; c = 0; sgn = 0; start = 1;
    sbq[0].push_back(model(16, 16'h1111, 16'h0101, 0, 0, cyc + 1 + 4));
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0000; c = 1; sgn = 1;
    wait_valid16("t5a");
    repeat (5) begin
      @(negedge clk);
      chk("t5 valid_held", 32'(valid), 1);
    end
    a = 16'h00FF; b = 16'h0F00; c = 1; sgn = 1; ack = 1;
    @(negedge clk);
    ack = 0;
    chk("t5 ready_after_ack", 32'(ready), 1);
    sbq[0].push_back(model(16, 16'h00FF, 16'h0F00, 1, 1, cyc + 1 + 4));
    @(negedge clk);
    start = 0;
    chk("t5 busy_second", 32'(busy), 1);
    wait_valid16("t5b");
    ack = 1;
    @(negedge clk);
    ack = 0;

    // reset two RUN cycles into an operation
    @(negedge clk);
    chk("t6 ready", 32'(ready), 1);
    a = 16'hABCD; b = 16'h1234; c = 0; sgn = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("t6 ready", 32'(ready), 1);
    chk("t6 busy", 32'(busy), 0);
    chk("t6 valid", 32'(valid), 0);
    chk("t6 diff", 32'(diff), 0);
    chk("t6 flags", {29'b0, borrow, ovf, zero}, 0);
    rst_n = 1;
    op16(16'hABCD, 16'h1234, 0, 0, 1);
    op16(16'h4000, 16'hC000, 0, 1, 0);

    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("sb%0d drained", i), sbq[i].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
